// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display driver:
// glyph codes beyond the decimal digits, the all-dark pattern and segment
// bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} bus.
package seg_pkg;

    // Non-numeric glyph codes (codes 0-9 render the decimal digits)
    localparam logic [3:0] GLYPH_A   = 4'hA;
    localparam logic [3:0] GLYPH_R   = 4'hB;
    localparam logic [3:0] GLYPH_G   = 4'hC;
    localparam logic [3:0] GLYPH_E   = 4'hD;
    localparam logic [3:0] GLYPH_EQ  = 4'hE;
    localparam logic [3:0] GLYPH_OFF = 4'hF;

    // Segment bus is active-low, so all ones is fully dark
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Bit positions in the segment bus
    localparam int SEG_A_BIT  = 0;
    localparam int SEG_B_BIT  = 1;
    localparam int SEG_C_BIT  = 2;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 4;
    localparam int SEG_F_BIT  = 5;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    // Digit index width; a single-digit display still keeps a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational glyph decoder: 4-bit glyph code to active-low {g,f,e,d,c,b,a}.
// Instanced once on the currently selected digit's glyph.
module seg7_glyph_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg7
);

    // Glyph lookup; unknown and OFF codes leave every segment dark
    always_comb begin
        seg7 = 7'h7F;
        case (code)
            4'h0:      seg7 = 7'h40;
            4'h1:      seg7 = 7'h79;
            4'h2:      seg7 = 7'h24;
            4'h3:      seg7 = 7'h30;
            4'h4:      seg7 = 7'h19;
            4'h5:      seg7 = 7'h12;
            4'h6:      seg7 = 7'h02;
            4'h7:      seg7 = 7'h78;
            4'h8:      seg7 = 7'h00;
            4'h9:      seg7 = 7'h10;
            GLYPH_A:   seg7 = 7'h08;
            GLYPH_R:   seg7 = 7'h2F;
            GLYPH_G:   seg7 = 7'h10;
            GLYPH_E:   seg7 = 7'h06;
            GLYPH_EQ:  seg7 = 7'h37;
            GLYPH_OFF: seg7 = 7'h7F;
            default:   seg7 = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed seven-segment driver. One active-low anode is driven
// per scan slot; anode and segments are registered together on the slot tick
// from the newly selected digit. Supports per-digit blink/blank masks and
// decimal points, with a free-running blink phase that can be resynchronised.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 100000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   glyphs,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      blink_sync,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                seg,
    output logic                      blink_phase
);

    localparam int IDX_W   = idx_width(NUM_DIGITS);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
        $fatal(1, "seg_scan_driver: NUM_DIGITS must be 1..8 and both dividers >= 2");
    end

    logic [SCAN_W-1:0]     scan_cnt_r;
    logic [BLINK_W-1:0]    blink_cnt_r;
    logic [IDX_W-1:0]      digit_idx_r;
    logic                  blink_phase_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [7:0]            seg_r;

    logic                  scan_tick_s;
    logic                  blink_tick_s;
    logic [IDX_W-1:0]      next_idx_s;
    logic [3:0]            glyph_sel_s;
    logic [6:0]            glyph_seg_s;
    logic [NUM_DIGITS-1:0] an_next_s;
    logic [7:0]            seg_next_s;

    assign scan_tick_s  = (scan_cnt_r == SCAN_LAST);
    assign blink_tick_s = (blink_cnt_r == BLINK_LAST);

    // Digit that becomes active at the next scan tick, wrapping after the last
    always_comb begin
        next_idx_s = {IDX_W{1'b0}};
        if (digit_idx_r == IDX_LAST) begin
            next_idx_s = {IDX_W{1'b0}};
        end else begin
            next_idx_s = digit_idx_r + IDX_W'(1);
        end
    end

    // Select the upcoming digit's glyph for the single shared decoder
    always_comb begin
        glyph_sel_s = glyphs[{next_idx_s, 2'b00} +: 4];
    end

    seg7_glyph_decoder u_decoder (
        .code (glyph_sel_s),
        .seg7 (glyph_seg_s)
    );

    // Build the anode/segment pair for the upcoming digit, applying masks
    always_comb begin
        an_next_s             = {NUM_DIGITS{1'b1}};
        an_next_s[next_idx_s] = 1'b0;
        seg_next_s            = SEG_OFF;
        if (blank_mask[next_idx_s] || (blink_mask[next_idx_s] && blink_phase_r)) begin
            seg_next_s = SEG_OFF;
        end else begin
            seg_next_s = {~dp[next_idx_s], glyph_seg_s};
        end
    end

    // Scan slot counter; wraps on its terminal count, which is the slot tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
        end else if (scan_tick_s) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Active digit index and registered anode/segment outputs, updated per tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx_r <= {IDX_W{1'b0}};
            an_r        <= {NUM_DIGITS{1'b1}};
            seg_r       <= SEG_OFF;
        end else if (scan_tick_s) begin
            digit_idx_r <= next_idx_s;
            an_r        <= an_next_s;
            seg_r       <= seg_next_s;
        end
    end

    // Blink half-period counter and phase; a sync pulse overrides the toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (blink_sync) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (blink_tick_s) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + BLINK_W'(1);
        end
    end

    assign an          = an_r;
    assign seg         = seg_r;
    assign blink_phase = blink_phase_r;

endmodule
